// File: rtl/div_seq.sv
// div_seq: multi-cycle iterative DIV/IDIV unit beside the execute-stage ALU.
// Restoring radix-2 division; word (32/16) and byte (16/8) modes, signed or
// unsigned. Result format {remainder, quotient}; div_err flags INT 0 cases.
// Optional macro DIV_RADIX4_EN retires two quotient bits per DIV cycle.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [15:0] y,
  input  logic        signed_op,
  input  logic        word_op,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        div_err
);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

`ifdef DIV_RADIX4_EN
  localparam logic [3:0] CNT_WORD = 4'd7;
  localparam logic [3:0] CNT_BYTE = 4'd3;
`else
  localparam logic [3:0] CNT_WORD = 4'd15;
  localparam logic [3:0] CNT_BYTE = 4'd7;
`endif

  state_t      state_reg, state_next;
  logic [15:0] rem_reg;      // partial remainder
  logic [15:0] lo_reg;       // dividend bits still to consume, quotient shifts in at LSB
  logic [15:0] dvs_reg;      // divisor magnitude
  logic [3:0]  cnt_reg;
  logic        word_reg;
  logic        signed_reg;
  logic        sign_q_reg;
  logic        sign_r_reg;
  logic [31:0] out_reg;
  logic        err_reg;

  // One restoring step: trial-subtract divisor from {rem, next dividend bit}.
  // rem < d always holds, so the 17-bit trial never overflows and bit 16 is
  // the borrow; byte mode runs on the zero-extended 9-bit trial.
  function automatic logic [31:0] div_step(input logic [15:0] rem,
                                           input logic [15:0] lo,
                                           input logic [15:0] d);
    logic [16:0] part;
    logic [16:0] trial;
    part  = {rem, lo[15]};
    trial = part - {1'b0, d};
    if (!trial[16])
      div_step = {trial[15:0], lo[14:0], 1'b1};
    else
      div_step = {part[15:0], lo[14:0], 1'b0};
  endfunction

  // Operand magnitudes and early-error detection for the start cycle
  logic        sx, sy;
  logic [31:0] dvd_mag;
  logic [15:0] dvs_mag;
  logic        early_err;
  logic [15:0] rem_init, lo_init;

  always_comb begin
    sx = signed_op & (word_op ? x[31] : x[15]);
    sy = signed_op & (word_op ? y[15] : y[7]);
    if (word_op) begin
      dvd_mag = sx ? (~x + 32'd1) : x;
      dvs_mag = sy ? (~y + 16'd1) : y;
    end else begin
      dvd_mag = {16'd0, (sx ? (~x[15:0] + 16'd1) : x[15:0])};
      dvs_mag = {8'd0, (sy ? (~y[7:0] + 8'd1) : y[7:0])};
    end
    if (word_op) begin
      early_err = (dvs_mag == 16'd0) || (dvd_mag[31:16] >= dvs_mag);
      rem_init  = dvd_mag[31:16];
      lo_init   = dvd_mag[15:0];
    end else begin
      early_err = (dvs_mag == 16'd0) || (dvd_mag[15:8] >= dvs_mag[7:0]);
      rem_init  = {8'd0, dvd_mag[15:8]};
      lo_init   = {dvd_mag[7:0], 8'd0};
    end
  end

  // Iteration datapath (one or two cascaded steps per cycle)
  logic [31:0] step1, step_res;
  always_comb begin
    step1 = div_step(rem_reg, lo_reg, dvs_reg);
`ifdef DIV_RADIX4_EN
    step_res = div_step(step1[31:16], step1[15:0], dvs_reg);
`else
    step_res = step1;
`endif
  end

  // Sign fix-up and signed range check on the final magnitudes
  logic [15:0] quo16, rem16;
  logic [7:0]  quo8, rem8;
  logic        ovf;
  logic [31:0] fix_out;
  always_comb begin
    quo16   = sign_q_reg ? (~lo_reg + 16'd1) : lo_reg;
    rem16   = sign_r_reg ? (~rem_reg + 16'd1) : rem_reg;
    quo8    = sign_q_reg ? (~lo_reg[7:0] + 8'd1) : lo_reg[7:0];
    rem8    = sign_r_reg ? (~rem_reg[7:0] + 8'd1) : rem_reg[7:0];
    ovf     = signed_reg & (word_reg ? lo_reg[15] : lo_reg[7]);
    fix_out = 32'd0;
    if (!ovf)
      fix_out = word_reg ? {rem16, quo16} : {16'd0, rem8, quo8};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (start) state_next = early_err ? DONE : DIV;
      DIV:  if (cnt_reg == 4'd0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_reg == DIV) || (state_reg == FIX);
    done = (state_reg == DONE);
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg    <= 16'd0;
      lo_reg     <= 16'd0;
      dvs_reg    <= 16'd0;
      cnt_reg    <= 4'd0;
      word_reg   <= 1'b0;
      signed_reg <= 1'b0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      out_reg    <= 32'd0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          rem_reg    <= rem_init;
          lo_reg     <= lo_init;
          dvs_reg    <= dvs_mag;
          cnt_reg    <= word_op ? CNT_WORD : CNT_BYTE;
          word_reg   <= word_op;
          signed_reg <= signed_op;
          sign_q_reg <= sx ^ sy;
          sign_r_reg <= sx;
          out_reg    <= 32'd0;
          err_reg    <= early_err;
        end
        DIV: begin
          rem_reg <= step_res[31:16];
          lo_reg  <= step_res[15:0];
          cnt_reg <= cnt_reg - 4'd1;
        end
        FIX: begin
          out_reg <= fix_out;
          err_reg <= ovf;
        end
        default: ;
      endcase
    end
  end

  assign out     = out_reg;
  assign div_err = err_reg;

endmodule
